stopwatch_ctrl: RTL
===================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, counter width in bits (WIDTH >= 4).
REQ-002 SHALL have parameter DIV, default 50000000, clk cycles per count increment (DIV >= 2).
REQ-003 SHALL have parameter SCAN_DIV, default 50000, clk cycles each display digit stays selected (SCAN_DIV >= 1).
REQ-004 SHALL have parameter STOP_AT_MAX, default 0; 0 = count wraps, 1 = count halts at all-ones.
REQ-005 SHALL define NDIG = (WIDTH-1)/4+1, the number of hex digits covering the counter.
REQ-006 SHALL have clk  input  1  sole clock; all logic on rising edge.
REQ-007 SHALL have rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have start_stop  input  1  single-cycle pulse that toggles run/pause.
REQ-009 SHALL have clear  input  1  single-cycle pulse that returns to IDLE with count zeroed.
REQ-010 SHALL have count  output  WIDTH  current counter value, registered.
REQ-011 SHALL have tick  output  1  one-cycle pulse in the cycle that count increments.
REQ-012 SHALL have wrap  output  1  one-cycle pulse when count goes from all-ones to 0.
REQ-013 SHALL have state_o  output  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE.
REQ-014 SHALL have digit_sel  output  NDIG  one-hot, active-high digit enable for the multiplexed display.
REQ-015 SHALL have digit_nib  output  4  nibble of count for the selected digit, feeding an external hex-to-7-segment decoder.

Function
REQ-016 FSM: IDLE --start_stop--> RUN; RUN --start_stop--> PAUSE; PAUSE --start_stop--> RUN; any state --clear--> IDLE.
REQ-017 clear SHALL take priority over start_stop in the same cycle.
REQ-018 In IDLE, count and prescaler SHALL be held at 0.
REQ-019 In RUN, prescaler SHALL count 0..DIV-1; in the cycle prescaler = DIV-1, tick = 1, prescaler -> 0, and count increments on that edge.
REQ-020 First increment SHALL occur DIV cycles after the cycle RUN is entered.
REQ-021 In PAUSE, prescaler and count SHALL hold; on resuming RUN, counting continues from the held prescaler value.
REQ-022 If start_stop arrives in the same cycle as prescaler = DIV-1 in RUN, the increment SHALL occur and the FSM SHALL go to PAUSE.
REQ-023 STOP_AT_MAX = 0: increment from all-ones SHALL produce 0 with wrap = 1 in the same cycle as tick.
REQ-024 STOP_AT_MAX = 1: increment reaching all-ones SHALL move the FSM to DONE; wrap SHALL never assert; DONE ignores start_stop and holds count; only clear exits.
REQ-025 tick and wrap SHALL be 0 in IDLE, PAUSE and DONE.
REQ-026 Scan counter SHALL run in every FSM state, advancing digit_sel one position every SCAN_DIV cycles (bit 0 -> bit 1 -> ... -> bit NDIG-1 -> bit 0).
REQ-027 digit_nib SHALL equal count[4k+3:4k] when digit_sel bit k is set; bits above WIDTH-1 SHALL read as 0.
REQ-028 digit_sel SHALL be exactly one-hot in every cycle.

Reset
REQ-029 rst SHALL override all inputs and, on the next edge, set state IDLE, count 0, prescaler 0, tick 0, wrap 0, digit_sel = 1 (digit 0), scan counter 0.
REQ-030 rst asserted mid-RUN or mid-DONE SHALL give the same result as REQ-029, with no residual tick.

Verification (WIDTH=8, DIV=4, SCAN_DIV=2 unless noted)
REQ-031 Reset, start_stop pulse, run 12 cycles -> count = 3, tick pulses 4 cycles apart, first tick 4 cycles after RUN entry.
REQ-032 RUN to count = 2 with prescaler = 1, pause 10 cycles, resume -> count remains 2 while paused; next tick 3 cycles after resume.
REQ-033 Force count to 8'hFF (run 1020 cycles), next tick -> count = 8'h00, wrap = 1 for one cycle; with STOP_AT_MAX=1 -> count holds 8'hFF, state_o = 11, start_stop ignored, clear -> state_o = 00, count = 0.
REQ-034 start_stop and clear in the same cycle during RUN -> state_o = 00, count = 0, no tick.
REQ-035 count = 8'hA5 -> digit_sel alternates 01, 10 every 2 cycles; digit_nib = 5 with 01, A with 10; with WIDTH=10, digit_sel cycles 001, 010, 100, top nibble zero-padded.
REQ-036 rst asserted on the cycle prescaler = DIV-1 in RUN -> next cycle count = 0, tick = 0, state_o = 00, digit_sel = 1.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear stopwatch with a prescaled binary counter and a
// time-multiplexed hex digit scanner for an external 7-segment decoder.
module stopwatch_ctrl #(
  parameter int WIDTH       = 16,
  parameter int DIV         = 50000000,
  parameter int SCAN_DIV    = 50000,
  parameter int STOP_AT_MAX = 0,
  localparam int NDIG       = (WIDTH - 1) / 4 + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_stop,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             wrap,
  output logic [1:0]       state_o,
  output logic [NDIG-1:0]  digit_sel,
  output logic [3:0]       digit_nib
);

  localparam int PW = $clog2(DIV);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0]    PRESC_ZERO = '0;
  localparam logic [SW-1:0]    SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0]    SCAN_ZERO  = '0;
  localparam logic [WIDTH-1:0] CNT_ZERO   = '0;
  localparam logic [WIDTH-1:0] CNT_ONES   = '1;
  localparam logic [NDIG-1:0]  SEL_FIRST  = NDIG'(1);
  localparam bit               STOP_EN    = (STOP_AT_MAX != 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic [SW-1:0]    scan_q, scan_d;
  logic [NDIG-1:0]  sel_q, sel_d;
  logic [3:0]       nib_q, nib_d;

  logic             last_s;
  logic [WIDTH-1:0] cnt_inc_s;
  logic [NDIG-1:0]  sel_rot_s;
  logic [NDIG*4-1:0] padded_s;
  logic [NDIG*4-1:0] masked_s;
  logic [NDIG:0][3:0] nib_acc_s;

  assign last_s    = (presc_q == PRESC_LAST);
  assign cnt_inc_s = count_q + WIDTH'(1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear wins over start_stop, reaching max in stop mode wins over pause
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  state_d = start_stop ? S_RUN : S_IDLE;
        S_RUN: begin
          if (STOP_EN && last_s && (cnt_inc_s == CNT_ONES)) begin
            state_d = S_DONE;
          end else if (start_stop) begin
            state_d = S_PAUSE;
          end else begin
            state_d = S_RUN;
          end
        end
        S_PAUSE: state_d = start_stop ? S_RUN : S_PAUSE;
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Prescaler/counter next values and the tick/wrap strobes for the coming cycle
  always_comb begin
    presc_d = presc_q;
    count_d = count_q;
    if (clear) begin
      presc_d = PRESC_ZERO;
      count_d = CNT_ZERO;
    end else begin
      case (state_q)
        S_IDLE: begin
          presc_d = PRESC_ZERO;
          count_d = CNT_ZERO;
        end
        S_RUN: begin
          if (last_s) begin
            presc_d = PRESC_ZERO;
            count_d = cnt_inc_s;
          end else begin
            presc_d = presc_q + PW'(1);
            count_d = count_q;
          end
        end
        S_PAUSE, S_DONE: begin
          presc_d = presc_q;
          count_d = count_q;
        end
        default: begin
          presc_d = PRESC_ZERO;
          count_d = CNT_ZERO;
        end
      endcase
    end
    // Strobes are predicted one cycle ahead so they come straight out of flops
    tick_d = (state_d == S_RUN) && (presc_d == PRESC_LAST);
    wrap_d = tick_d && !STOP_EN && (count_d == CNT_ONES);
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= PRESC_ZERO;
      count_q <= CNT_ZERO;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  for (genvar k = 0; k < NDIG; k++) begin : g_rot
    assign sel_rot_s[k] = sel_q[(k + NDIG - 1) % NDIG];
  end

  // Scan divider and digit rotation; a corrupted select vector recovers to digit 0
  always_comb begin
    scan_d = scan_q;
    sel_d  = sel_q;
    if (!$onehot(sel_q)) begin
      scan_d = SCAN_ZERO;
      sel_d  = SEL_FIRST;
    end else if (scan_q >= SCAN_LAST) begin
      scan_d = SCAN_ZERO;
      sel_d  = sel_rot_s;
    end else begin
      scan_d = scan_q + SW'(1);
      sel_d  = sel_q;
    end
  end

  // Zero-extend the next count to whole nibbles, then AND-OR select the active digit
  always_comb begin
    padded_s = '0;
    padded_s[WIDTH-1:0] = count_d;
  end

  assign nib_acc_s[0] = 4'h0;
  for (genvar k = 0; k < NDIG; k++) begin : g_nib
    assign masked_s[4*k +: 4] = padded_s[4*k +: 4] & {4{sel_d[k]}};
    assign nib_acc_s[k+1]     = nib_acc_s[k] | masked_s[4*k +: 4];
  end
  assign nib_d = nib_acc_s[NDIG];

  // Display scan registers
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_q <= SCAN_ZERO;
      sel_q  <= SEL_FIRST;
      nib_q  <= 4'h0;
    end else begin
      scan_q <= scan_d;
      sel_q  <= sel_d;
      nib_q  <= nib_d;
    end
  end

  assign count     = count_q;
  assign tick      = tick_q;
  assign wrap      = wrap_q;
  assign state_o   = state_q;
  assign digit_sel = sel_q;
  assign digit_nib = nib_q;

endmodule
